// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs the imem handshake with at most one request
// in flight, buffers responses in a small FIFO for decode. Optional counters: FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_ID,
  input  logic        redirect_EX,
  input  logic [31:0] redirect_pc_EX,
  output logic [31:0] instr_ID,
  output logic [31:0] pc_ID,
  output logic [31:0] pc_plus4_ID,
  output logic        valid_ID,
  output logic        err_IF,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_squash_cnt
);

  localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SQUASH} state_t;

  state_t        state, state_nx;
  logic [31:0]   fetch_pc, pending_pc;
  logic          outstanding, discard;
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          rsp, push, pop, grant, full;

  // rvalid is only meaningful with a request in flight, which also masks the post-reset cycle
  assign rsp      = imem_rvalid & outstanding;
  assign full     = (count == CW'(BUF_DEPTH));
  assign valid_ID = (count != '0);
  assign push     = rsp & ~discard & ~redirect_EX;
  assign pop      = valid_ID & ~stall_ID & ~redirect_EX;
  assign grant    = imem_req & imem_gnt;

  assign imem_addr   = fetch_pc;
  assign instr_ID    = valid_ID ? buf_instr[rd_ptr] : NOP_INSTR;
  assign pc_ID       = valid_ID ? buf_pc[rd_ptr] : 32'h0000_0000;
  assign pc_plus4_ID = pc_ID + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    unique case (state)
      S_IDLE: state_nx = S_RUN;
      S_RUN: begin
        imem_req = ~outstanding & ~full & ~redirect_EX;
        if (redirect_EX && outstanding && !rsp) state_nx = S_SQUASH;
      end
      S_SQUASH: if (rsp) state_nx = S_RUN;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      pending_pc  <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      err_IF      <= 1'b0;
    end else begin
      if (redirect_EX)  fetch_pc <= {redirect_pc_EX[31:2], 2'b00};
      else if (grant)   fetch_pc <= fetch_pc + 32'd4;
      if (grant)        pending_pc <= fetch_pc;
      if (grant)        outstanding <= 1'b1;
      else if (rsp)     outstanding <= 1'b0;
      // a response landing in the redirect cycle is already dropped, so no discard is armed
      if (redirect_EX && outstanding && !rsp) discard <= 1'b1;
      else if (rsp && discard)                discard <= 1'b0;
      if (redirect_EX && (redirect_pc_EX[1:0] != 2'b00)) err_IF <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_EX) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]    <= pending_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, squash_cnt;
  logic [32:0] squash_sum;

  always_comb begin
    squash_sum = {1'b0, squash_cnt};
    if (redirect_EX)                         squash_sum = squash_sum + 33'(count);
    if (rsp && (discard || redirect_EX))     squash_sum = squash_sum + 33'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (valid_ID && stall_ID && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      squash_cnt <= squash_sum[32] ? '1 : squash_sum[31:0];
    end
  end

  assign perf_stall_cnt  = stall_cnt;
  assign perf_squash_cnt = squash_cnt;
`else
  assign perf_stall_cnt  = '0;
  assign perf_squash_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small imem responder with configurable latency,
// per-scenario tasks with inline checks against hand-derived PC/instruction sequences.
module tb_fetch_stage;

  logic        clk, rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall_ID, redirect_EX;
  logic [31:0] redirect_pc_EX;
  logic [31:0] instr_ID, pc_ID, pc_plus4_ID;
  logic        valid_ID, err_IF;
  logic [31:0] perf_stall_cnt, perf_squash_cnt;

  int          checks = 0;
  int          failures = 0;
  int unsigned mem_lat = 1;
  int unsigned wait_left = 0;
  logic [31:0] resp_addr = '0;
  logic [31:0] exp_pc;
  logic [31:0] granted [$];
  int          pops;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .stall_ID        (stall_ID),
    .redirect_EX     (redirect_EX),
    .redirect_pc_EX  (redirect_pc_EX),
    .instr_ID        (instr_ID),
    .pc_ID           (pc_ID),
    .pc_plus4_ID     (pc_plus4_ID),
    .valid_ID        (valid_ID),
    .err_IF          (err_IF),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_squash_cnt (perf_squash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  // One clock: drive the responder for this cycle, note a grant, advance to the next negedge.
  task automatic cycle();
    logic        g;
    logic [31:0] ga;
    imem_rvalid = (wait_left == 1);
    imem_rdata  = imem_rvalid ? mem_word(resp_addr) : 32'hDEAD_BEEF;
    #1;
    g  = imem_req & imem_gnt;
    ga = imem_addr;
    @(posedge clk);
    if (wait_left > 0) wait_left--;
    if (g) begin
      wait_left = mem_lat;
      resp_addr = ga;
      granted.push_back(ga);
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    stall_ID = 1'b0;
    redirect_EX = 1'b0;
    redirect_pc_EX = '0;
    imem_gnt = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    wait_left = 0;
    granted.delete();
    pops = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_stream(input int n);
    for (int i = 0; i < n; i++) begin
      if (valid_ID && !stall_ID) begin
        checks++;
        if (pc_ID !== exp_pc) begin
          failures++;
          $display("FAIL stream_pc: got %h expected %h", pc_ID, exp_pc);
        end
        checks++;
        if (instr_ID !== mem_word(exp_pc)) begin
          failures++;
          $display("FAIL stream_instr: got %h expected %h", instr_ID, mem_word(exp_pc));
        end
        checks++;
        if (pc_plus4_ID !== exp_pc + 32'd4) begin
          failures++;
          $display("FAIL stream_pc4: got %h expected %h", pc_plus4_ID, exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      cycle();
    end
  endtask

  task automatic test_reset();
    mem_lat = 1;
    apply_reset();
    checks++;
    if ({imem_req, valid_ID, err_IF} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got req/valid/err=%b expected 000", {imem_req, valid_ID, err_IF});
    end
    checks++;
    if (instr_ID !== 32'h0000_0013) begin
      failures++;
      $display("FAIL reset_instr: got %h expected 00000013", instr_ID);
    end
    checks++;
    if ({pc_ID, pc_plus4_ID} !== {32'h0, 32'h4}) begin
      failures++;
      $display("FAIL reset_pc: got %h/%h expected 00000000/00000004", pc_ID, pc_plus4_ID);
    end
    checks++;
    if ({perf_stall_cnt, perf_squash_cnt} !== 64'h0) begin
      failures++;
      $display("FAIL reset_perf: got %h/%h expected 0/0", perf_stall_cnt, perf_squash_cnt);
    end
    rst = 1'b1;
    wait_left = 1;             // stray rvalid in the first cycle after release
    resp_addr = 32'h0000_0500;
    cycle();
    checks++;
    if (valid_ID !== 1'b0) begin
      failures++;
      $display("FAIL reset_stray_rvalid: got valid=%b expected 0", valid_ID);
    end
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL reset_first_req: got %b/%h expected 1/00000000", imem_req, imem_addr);
    end
    cycle();
    checks++;
    if (valid_ID !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid_c2: got %b expected 0", valid_ID);
    end
    cycle();
    checks++;
    if ({valid_ID, pc_ID, pc_plus4_ID} !== {1'b1, 32'h0, 32'h4}) begin
      failures++;
      $display("FAIL reset_first_valid: got %b/%h/%h expected 1/00000000/00000004",
               valid_ID, pc_ID, pc_plus4_ID);
    end
    checks++;
    if (instr_ID !== 32'hCAFE_0000) begin
      failures++;
      $display("FAIL reset_first_instr: got %h expected cafe0000", instr_ID);
    end
  endtask

  task automatic test_stream();
    mem_lat = 1;
    apply_reset();
    rst = 1'b1;
    exp_pc = 32'h0;
    run_stream(16);
    checks++;
    if (pops !== 7) begin
      failures++;
      $display("FAIL stream_pops: got %0d expected 7", pops);
    end
    checks++;
    if (granted.size() !== 8) begin
      failures++;
      $display("FAIL stream_grants: got %0d expected 8", granted.size());
    end
    for (int i = 0; i < granted.size(); i++) begin
      checks++;
      if (granted[i] !== 32'(i * 4)) begin
        failures++;
        $display("FAIL stream_addr[%0d]: got %h expected %h", i, granted[i], 32'(i * 4));
      end
    end
  endtask

  task automatic test_stall();
    int tries;
    mem_lat = 1;
    apply_reset();
    rst = 1'b1;
    exp_pc = 32'h0;
    run_stream(8);
    tries = 0;
    while (!valid_ID && tries < 10) begin
      cycle();
      tries++;
    end
    checks++;
    if (valid_ID !== 1'b1) begin
      failures++;
      $display("FAIL stall_wait_valid: got %b expected 1", valid_ID);
    end
    stall_ID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({valid_ID, pc_ID} !== {1'b1, exp_pc}) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got %b/%h expected 1/%h", i, valid_ID, pc_ID, exp_pc);
      end
      cycle();
    end
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL stall_req_stop: got %b expected 0", imem_req);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_stall_cnt !== 32'd5) begin
      failures++;
      $display("FAIL stall_perf: got %0d expected 5", perf_stall_cnt);
    end
`else
    checks++;
    if (perf_stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL stall_perf_off: got %0d expected 0", perf_stall_cnt);
    end
`endif
    stall_ID = 1'b0;
    pops = 0;
    run_stream(10);
    checks++;
    if (pops < 4) begin
      failures++;
      $display("FAIL stall_resume: got %0d pops expected at least 4", pops);
    end
  endtask

  task automatic test_redirect();
    int tries;
    logic wrong;
    mem_lat = 3;
    apply_reset();
    rst = 1'b1;
    redirect_EX = 1'b1;
    redirect_pc_EX = 32'h0000_0010;
    cycle();
    redirect_EX = 1'b0;
    cycle();
    checks++;
    if ((granted.size() !== 1) || (granted[0] !== 32'h10)) begin
      failures++;
      $display("FAIL redir_setup: got %0d grants first %h expected 1 grant 00000010",
               granted.size(), granted[0]);
    end
    redirect_EX = 1'b1;
    redirect_pc_EX = 32'h0000_0100;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL redir_no_req: got %b expected 0", imem_req);
    end
    cycle();
    redirect_EX = 1'b0;
    tries = 0;
    wrong = 1'b0;
    while (!valid_ID && tries < 20) begin
      cycle();
      tries++;
    end
    if (valid_ID && pc_ID !== 32'h100) wrong = 1'b1;
    checks++;
    if ({valid_ID, wrong} !== 2'b10) begin
      failures++;
      $display("FAIL redir_valid: got valid=%b wrongpc=%b expected 1/0", valid_ID, wrong);
    end
    checks++;
    if ({pc_ID, instr_ID} !== {32'h100, 32'hCAFE_0100}) begin
      failures++;
      $display("FAIL redir_target: got %h/%h expected 00000100/cafe0100", pc_ID, instr_ID);
    end
    checks++;
    if ((granted.size() !== 2) || (granted[1] !== 32'h100)) begin
      failures++;
      $display("FAIL redir_next_addr: got %0d grants last %h expected 2 grants 00000100",
               granted.size(), granted[granted.size() - 1]);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_squash_cnt !== 32'd1) begin
      failures++;
      $display("FAIL redir_perf: got %0d expected 1", perf_squash_cnt);
    end
`endif
  endtask

  task automatic test_misaligned();
    int tries;
    mem_lat = 1;
    apply_reset();
    stall_ID = 1'b1;
    rst = 1'b1;
    tries = 0;
    while (!(granted.size() == 2 && wait_left == 0) && tries < 20) begin
      cycle();
      tries++;
    end
    checks++;
    if ({imem_req, valid_ID, pc_ID} !== {1'b0, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL mis_full: got req=%b valid=%b pc=%h expected 0/1/00000000",
               imem_req, valid_ID, pc_ID);
    end
    redirect_EX = 1'b1;
    redirect_pc_EX = 32'h0000_0202;
    cycle();
    redirect_EX = 1'b0;
    stall_ID = 1'b0;
    checks++;
    if ({valid_ID, err_IF} !== 2'b01) begin
      failures++;
      $display("FAIL mis_flush_err: got valid=%b err=%b expected 0/1", valid_ID, err_IF);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_squash_cnt !== 32'd2) begin
      failures++;
      $display("FAIL mis_perf: got %0d expected 2", perf_squash_cnt);
    end
`endif
    tries = 0;
    while (!valid_ID && tries < 10) begin
      cycle();
      tries++;
    end
    checks++;
    if ({valid_ID, pc_ID} !== {1'b1, 32'h200}) begin
      failures++;
      $display("FAIL mis_target: got %b/%h expected 1/00000200", valid_ID, pc_ID);
    end
    checks++;
    if ((granted.size() < 3) || (granted[2] !== 32'h200)) begin
      failures++;
      $display("FAIL mis_addr: got %0d grants expected third grant 00000200", granted.size());
    end
    redirect_EX = 1'b1;
    redirect_pc_EX = 32'h0000_0300;
    cycle();
    redirect_EX = 1'b0;
    cycle();
    checks++;
    if (err_IF !== 1'b1) begin
      failures++;
      $display("FAIL mis_sticky: got %b expected 1", err_IF);
    end
  endtask

  task automatic test_gnt_low();
    mem_lat = 1;
    apply_reset();
    imem_gnt = 1'b0;
    rst = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
        failures++;
        $display("FAIL gnt_hold_addr[%0d]: got %b/%h expected 1/00000000", i, imem_req, imem_addr);
      end
      checks++;
      if ({valid_ID, instr_ID} !== {1'b0, 32'h0000_0013}) begin
        failures++;
        $display("FAIL gnt_nop[%0d]: got %b/%h expected 0/00000013", i, valid_ID, instr_ID);
      end
      cycle();
    end
    imem_gnt = 1'b1;
    exp_pc = 32'h0;
    run_stream(6);
    checks++;
    if ((pops !== 2) || (granted[0] !== 32'h0)) begin
      failures++;
      $display("FAIL gnt_resume: got pops=%0d first=%h expected 2/00000000", pops, granted[0]);
    end
  endtask

  task automatic test_wrap();
    mem_lat = 1;
    apply_reset();
    rst = 1'b1;
    redirect_EX = 1'b1;
    redirect_pc_EX = 32'hFFFF_FFFC;
    cycle();
    redirect_EX = 1'b0;
    exp_pc = 32'hFFFF_FFFC;
    run_stream(8);
    checks++;
    if (pops !== 3) begin
      failures++;
      $display("FAIL wrap_pops: got %0d expected 3", pops);
    end
    checks++;
    if ((granted.size() < 2) || (granted[0] !== 32'hFFFF_FFFC) || (granted[1] !== 32'h0)) begin
      failures++;
      $display("FAIL wrap_addr: got %0d grants %h,%h expected fffffffc,00000000",
               granted.size(), granted[0], granted[1]);
    end
  endtask

  initial begin
    rst = 1'b0;
    stall_ID = 1'b0;
    redirect_EX = 1'b0;
    redirect_pc_EX = '0;
    imem_gnt = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_gnt_low();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
